// File: rtl/if_stage_buffer.sv
// -----------------------------------------------------------------------------
// if_stage_buffer
//
// IF/ID pipeline buffer: a DEPTH-entry circular FIFO of {PC, instruction}
// pairs sitting between instruction fetch and decode. Fetch may run ahead
// while decode is frozen. A flush empties the buffer in a single cycle, and
// out_valid marks bubbles explicitly; the data outputs read zero (NOP) when
// the buffer is empty.
//
// Ports
//   CLK                    clock, all state updates on the rising edge
//   RST                    synchronous active-high reset (same effect as flush)
//   flush                  discard every buffered entry; dominates push/pop
//   in_valid / in_ready    fetch-side handshake (push = in_valid & in_ready)
//   PC_In                  PC of the fetched instruction
//   InstructionMemory_In   fetched instruction word
//   freeze                 decode stalled, head entry is held
//   out_valid              head entry holds a valid pair
//   PC_Out                 head PC, zero when out_valid = 0
//   InstructionMemory_Out  head instruction, zero when out_valid = 0
//   count                  number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module if_stage_buffer #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_WIDTH-1:0]   PC_In,
    input  logic [INST_WIDTH-1:0] InstructionMemory_In,
    input  logic                  freeze,
    output logic                  out_valid,
    output logic [PC_WIDTH-1:0]   PC_Out,
    output logic [INST_WIDTH-1:0] InstructionMemory_Out,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Pointers are exactly log2(DEPTH) bits so they wrap by overflow
    // (DEPTH is a power of two).
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Payload storage carries no reset: occupancy alone decides validity.
    logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];

    logic push;
    logic pop;
    logic wr_en;

    // Handshake flags come from registered occupancy only: no full-bypass,
    // so a full buffer refuses a push even while it pops.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & ~freeze;
    assign wr_en     = push & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Flush wins over any push or pop in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage: written on an accepted, non-flushed push.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]   <= PC_In;
            inst_mem_q[wr_ptr_q] <= InstructionMemory_In;
        end
    end

    // Head entry is masked to zero so an empty buffer presents a NOP bubble.
    assign PC_Out                = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign InstructionMemory_Out = out_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign count                 = count_q;

endmodule

// File: tb/tb_if_stage_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_stage_buffer
//
// Bench for if_stage_buffer. Two builds are instantiated: the default
// (DEPTH=2, 32-bit PC) and a DEPTH=4, 16-bit PC variant. Directed stimulus
// pushes expected pairs into a per-build queue; a monitor per build compares
// the head entry against the queue front whenever out_valid is high and pops
// the queue when the head is consumed.
// -----------------------------------------------------------------------------
module tb_if_stage_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- DEPTH=2 build ----------------
    logic        rst = 1'b1;
    logic        d2_flush = 1'b0;
    logic        d2_in_valid = 1'b0;
    logic        d2_in_ready;
    logic [31:0] d2_pc_in = '0;
    logic [31:0] d2_inst_in = '0;
    logic        d2_freeze = 1'b0;
    logic        d2_out_valid;
    logic [31:0] d2_pc_out;
    logic [31:0] d2_inst_out;
    logic [1:0]  d2_count;

    if_stage_buffer #(
        .PC_WIDTH(32), .INST_WIDTH(32), .DEPTH(2)
    ) dut2 (
        .CLK(clk), .RST(rst), .flush(d2_flush),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .PC_In(d2_pc_in), .InstructionMemory_In(d2_inst_in),
        .freeze(d2_freeze), .out_valid(d2_out_valid),
        .PC_Out(d2_pc_out), .InstructionMemory_Out(d2_inst_out),
        .count(d2_count)
    );

    // ---------------- DEPTH=4, PC_WIDTH=16 build ----------------
    logic        d4_flush = 1'b0;
    logic        d4_in_valid = 1'b0;
    logic        d4_in_ready;
    logic [15:0] d4_pc_in = '0;
    logic [31:0] d4_inst_in = '0;
    logic        d4_freeze = 1'b0;
    logic        d4_out_valid;
    logic [15:0] d4_pc_out;
    logic [31:0] d4_inst_out;
    logic [2:0]  d4_count;

    if_stage_buffer #(
        .PC_WIDTH(16), .INST_WIDTH(32), .DEPTH(4)
    ) dut4 (
        .CLK(clk), .RST(rst), .flush(d4_flush),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .PC_In(d4_pc_in), .InstructionMemory_In(d4_inst_in),
        .freeze(d4_freeze), .out_valid(d4_out_valid),
        .PC_Out(d4_pc_out), .InstructionMemory_Out(d4_inst_out),
        .count(d4_count)
    );

    pair_t sb2[$];
    pair_t sb4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'hC0DE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pair into the DEPTH=2 build and record it as expected.
    task automatic offer2(input logic [31:0] pc);
        pair_t p;
        d2_in_valid = 1'b1;
        d2_pc_in    = pc;
        d2_inst_in  = inst_of(pc);
        p.pc   = pc;
        p.inst = inst_of(pc);
        sb2.push_back(p);
    endtask

    task automatic offer4(input logic [15:0] pc);
        pair_t p;
        d4_in_valid = 1'b1;
        d4_pc_in    = pc;
        d4_inst_in  = inst_of({16'h0, pc});
        p.pc   = {16'h0, pc};
        p.inst = inst_of({16'h0, pc});
        sb4.push_back(p);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && !d2_flush && d2_out_valid === 1'b1) begin
            if (sb2.size() == 0) begin
                chk("d2_unexpected_out", d2_pc_out, 32'hFFFF_FFFF);
            end else begin
                chk("d2_pc_out", d2_pc_out, sb2[0].pc);
                chk("d2_inst_out", d2_inst_out, sb2[0].inst);
                if (!d2_freeze) void'(sb2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !d4_flush && d4_out_valid === 1'b1) begin
            if (sb4.size() == 0) begin
                chk("d4_unexpected_out", {16'h0, d4_pc_out}, 32'hFFFF_FFFF);
            end else begin
                chk("d4_pc_out", {16'h0, d4_pc_out}, sb4[0].pc);
                chk("d4_inst_out", d4_inst_out, sb4[0].inst);
                if (!d4_freeze) void'(sb4.pop_front());
            end
        end
        if (!rst && d4_count !== 3'bxxx) begin
            chk("d4_count_le_depth", {31'h0, (d4_count > 3'd4)}, 32'h0);
            if (d4_count == 3'd4) chk("d4_no_ready_when_full", {31'h0, d4_in_ready}, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] pat;
        logic [3:0]  pidx;
        logic        acc;

        // Reset with a valid pair presented: nothing must be captured.
        rst = 1'b1;
        d2_in_valid = 1'b1;
        d2_pc_in    = 32'h40;
        d2_inst_in  = inst_of(32'h40);
        tick();
        tick();
        chk("rst_count", d2_count, 0);
        chk("rst_out_valid", d2_out_valid, 0);
        chk("rst_in_ready", d2_in_ready, 1);
        chk("rst_pc_out", d2_pc_out, 0);
        chk("rst_inst_out", d2_inst_out, 0);
        chk("rst_d4_count", d4_count, 0);
        rst = 1'b0;
        offer2(32'h40);
        tick();
        d2_in_valid = 1'b0;
        chk("post_rst_pc", d2_pc_out, 32'h40);
        chk("post_rst_count", d2_count, 1);
        tick();
        chk("post_rst_drain", d2_count, 0);

        // Streaming: one push and one pop per cycle.
        for (int i = 0; i < 4; i++) begin
            offer2(32'(i * 4));
            tick();
            chk("stream_count", d2_count, 1);
            chk("stream_pc", d2_pc_out, 32'(i * 4));
        end
        d2_in_valid = 1'b0;
        tick();
        chk("stream_drain", d2_count, 0);
        chk("stream_empty_pc", d2_pc_out, 0);

        // Fill while frozen, then release: full + pop rejects the push.
        d2_freeze = 1'b1;
        offer2(32'h100);
        tick();
        offer2(32'h104);
        tick();
        chk("fill_count", d2_count, 2);
        chk("fill_in_ready", d2_in_ready, 0);
        offer2(32'h108);
        tick();
        chk("hold_count", d2_count, 2);
        chk("hold_pc", d2_pc_out, 32'h100);
        d2_freeze = 1'b0;
        tick();
        chk("fullpop_count", d2_count, 1);
        chk("fullpop_in_ready", d2_in_ready, 1);
        chk("fullpop_pc", d2_pc_out, 32'h104);
        tick();
        d2_in_valid = 1'b0;
        chk("wrap_pc", d2_pc_out, 32'h108);
        chk("wrap_count", d2_count, 1);
        tick();
        chk("wrap_drain", d2_count, 0);

        // Flush with a full buffer and a pending pair.
        d2_freeze = 1'b1;
        offer2(32'h300);
        tick();
        offer2(32'h304);
        tick();
        chk("pre_flush_count", d2_count, 2);
        d2_freeze = 1'b0;
        d2_flush  = 1'b1;
        sb2.delete();
        d2_in_valid = 1'b1;
        d2_pc_in    = 32'h308;
        tick();
        d2_flush    = 1'b0;
        d2_in_valid = 1'b0;
        chk("flush_count", d2_count, 0);
        chk("flush_out_valid", d2_out_valid, 0);
        chk("flush_in_ready", d2_in_ready, 1);
        chk("flush_pc", d2_pc_out, 0);
        chk("flush_inst", d2_inst_out, 0);
        offer2(32'h200);
        tick();
        d2_in_valid = 1'b0;
        chk("after_flush_pc", d2_pc_out, 32'h200);
        tick();

        // Flush with simultaneous accepted push and pop.
        offer2(32'h400);
        tick();
        chk("pre_flush2_count", d2_count, 1);
        d2_flush = 1'b1;
        sb2.delete();
        d2_pc_in   = 32'h404;
        d2_inst_in = inst_of(32'h404);
        tick();
        d2_flush    = 1'b0;
        d2_in_valid = 1'b0;
        chk("flush2_count", d2_count, 0);
        chk("flush2_out_valid", d2_out_valid, 0);
        tick();
        chk("flush2_no_late_push", d2_count, 0);

        // Reset mid-operation drops the entry.
        offer2(32'h500);
        tick();
        rst = 1'b1;
        d2_in_valid = 1'b0;
        sb2.delete();
        tick();
        rst = 1'b0;
        chk("midrst_count", d2_count, 0);
        chk("midrst_out_valid", d2_out_valid, 0);
        chk("midrst_in_ready", d2_in_ready, 1);
        tick();
        chk("d2_sb_empty", sb2.size(), 0);

        // DEPTH=4 build: fill while frozen, then two more pairs under a
        // freeze pattern that toggles each cycle.
        d4_freeze = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer4(16'h1000 + 16'(k * 2));
            tick();
        end
        d4_in_valid = 1'b0;
        chk("d4_full_count", d4_count, 4);
        chk("d4_full_in_ready", d4_in_ready, 0);
        chk("d4_full_head", {16'h0, d4_pc_out}, 32'h1000);

        pat  = 16'b0110_1010_0110_0101;
        pidx = '0;
        for (int k = 4; k < 6; k++) begin
            offer4(16'h1000 + 16'(k * 2));
            acc = 1'b0;
            for (int c = 0; c < 40 && !acc; c++) begin
                d4_freeze = pat[pidx];
                pidx = pidx + 4'd1;
                @(negedge clk);
                acc = d4_in_ready;
                tick();
            end
            chk("d4_push_accepted", {31'h0, acc}, 32'h1);
        end
        d4_in_valid = 1'b0;
        d4_freeze   = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        chk("d4_drained_count", d4_count, 0);
        chk("d4_sb_empty", sb4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_stage_buffer.md
# if_stage_buffer

Parametrised IF/ID pipeline buffer replacing the single-entry fetch register: a DEPTH-entry FIFO of {PC, instruction} pairs between instruction fetch and decode. Fetch can run ahead while decode is frozen, a flush discards every buffered entry in one cycle, and a valid flag marks bubbles explicitly instead of relying on an all-zero instruction.

## Interface
Parameters:
- PC_WIDTH, 32, width of the PC field
- INST_WIDTH, 32, width of the instruction field
- DEPTH, 2, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (branch taken / exception)
- in_valid  in  1  fetch presents a valid pair
- in_ready  out  1  buffer can accept a pair this cycle
- PC_In  in  PC_WIDTH  PC of the fetched instruction
- InstructionMemory_In  in  INST_WIDTH  fetched instruction word
- freeze  in  1  decode stalled; head entry must not be consumed
- out_valid  out  1  head entry holds a valid pair
- PC_Out  out  PC_WIDTH  head PC; 0 when out_valid=0
- InstructionMemory_Out  out  INST_WIDTH  head instruction; 0 when out_valid=0 (NOP bubble)
- count  out  CNT_W  number of valid entries, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular array, write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits each, wrap naturally), occupancy register count.
- push = in_valid & in_ready. pop = out_valid & ~freeze.
- in_ready = (count != DEPTH); combinational from registered count only, with no dependence on pop in the same cycle (no full-bypass).
- out_valid = (count != 0). PC_Out and InstructionMemory_Out = entry[rd_ptr] when out_valid, else all zeros.
- Push only: write entry[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count−1.
- Push and pop together (count in 1..DEPTH−1): both pointers advance, count unchanged.
- Empty: pop is impossible (out_valid=0). An incoming push is not passed through; it appears on the outputs the next cycle.
- Full: in_ready=0, and in_valid is ignored even if a pop occurs that cycle.
- freeze=1: head entry and outputs hold; pushes still proceed until full.
- flush=1: wr_ptr, rd_ptr and count go to 0. Any push or pop in the same cycle is discarded, so flush dominates. Stored data need not be cleared; outputs read zero because out_valid=0.
- RST has priority over flush and all other inputs, with the same effect as flush. Reset mid-operation drops all entries.

## Timing
- Reset values, after the first CLK edge with RST=1: count=0, out_valid=0, in_ready=1, PC_Out=0, InstructionMemory_Out=0.
- Latency: a pair pushed at edge N is visible on the outputs after edge N when the buffer was empty. Otherwise it appears once all older entries have been popped.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- A flush asserted at edge N gives out_valid=0 and in_ready=1 after edge N, and a push is accepted at edge N+1.
- in_valid=1 with in_ready=0 is legal. The upstream holds PC_In and InstructionMemory_In until accepted; the buffer does not sample them.
- Outputs derive combinationally from registered state only; there are no input-to-output combinational paths.

## Test plan
- Reset: drive in_valid=1, PC_In=0x40 with RST=1 for 2 cycles → count=0, out_valid=0, outputs 0, in_ready=1. Release → push at the next edge, then PC_Out=0x40.
- Streaming: push PCs 0x0,0x4,0x8,0xC on consecutive cycles with freeze=0 → PC_Out 0x0,0x4,0x8,0xC each one cycle later, count stays 1, no gaps.
- Fill/freeze: freeze=1, push 0x100,0x104 (DEPTH=2) → count=2, in_ready=0, a third pair 0x108 is held off. Release freeze → outputs 0x100, then 0x104, then 0x108 is accepted. Order is preserved across pointer wrap.
- Flush with simultaneous push/pop: count=2, flush=1, in_valid=1, freeze=0 → after the edge count=0, out_valid=0, outputs 0, pushed pair discarded. Next push of 0x200 → PC_Out=0x200 one cycle later.
- Full + pop: count=DEPTH, freeze=0, in_valid=1 → pop occurs, push rejected, count=DEPTH−1, in_ready=1 the next cycle.
- DEPTH=4, PC_WIDTH=16 build: push 6 pairs with freeze toggling randomly → scoreboard confirms FIFO order, count never exceeds 4, and no in_valid&in_ready occurs while count=4.
